// File: rtl/instr_encoder_if.sv
// instr_encoder_if: descriptor handshake, memory write port and status between loader and encoder.
interface instr_encoder_if #(parameter int ADDR_WIDTH = 8);
  logic                  clear;
  logic                  in_valid;
  logic                  in_ready;
  logic [2:0]            format;
  logic [6:0]            opcode;
  logic [2:0]            funct3;
  logic [6:0]            funct7;
  logic [4:0]            rd;
  logic [4:0]            rs1;
  logic [4:0]            rs2;
  logic [31:0]           imm;
  logic                  mem_write;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_wdata;
  logic                  mem_ack;
  logic [ADDR_WIDTH:0]   count;
  logic                  full;
  logic                  error;
  modport master (
    output clear, in_valid, format, opcode, funct3, funct7, rd, rs1, rs2, imm, mem_ack,
    input  in_ready, mem_write, mem_addr, mem_wdata, count, full, error
  );
  modport slave (
    input  clear, in_valid, format, opcode, funct3, funct7, rd, rs1, rs2, imm, mem_ack,
    output in_ready, mem_write, mem_addr, mem_wdata, count, full, error
  );
endinterface

// File: rtl/instr_encoder.sv
// instr_encoder: packs RV32IM field descriptors into instruction words and writes them sequentially to memory.
module instr_encoder #(
  parameter int ADDR_WIDTH = 8,
  parameter int DEPTH      = 256
) (
  input logic           clk,
  input logic           reset,
  instr_encoder_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ENCODE, WRITE, STOP} state_t;
  localparam logic [ADDR_WIDTH:0] depth_w = (ADDR_WIDTH+1)'(DEPTH);
  state_t state, state_n;
  logic [2:0] fmt, f3;
  logic [6:0] op, f7;
  logic [4:0] rd, rs1, rs2;
  logic [31:0] imm, word;
  logic legal, accept, idle_clear;
  logic fits12, fits13, fits21;
  logic [ADDR_WIDTH:0] count_n;
  assign accept     = state == IDLE && bus.in_valid && !bus.clear;
  assign idle_clear = (state == IDLE || state == STOP) && bus.clear;
  assign count_n    = bus.count + 1'b1;
  // Range checks reduce to "upper bits are a sign extension of the field's top bit".
  assign fits12 = imm[31:11] == {21{imm[11]}};
  assign fits13 = imm[31:12] == {20{imm[12]}};
  assign fits21 = imm[31:20] == {12{imm[20]}};
  always_comb begin
    word  = '0;
    legal = 1'b0;
    case (fmt)
      3'd0: begin
        word  = {f7, rs2, rs1, f3, rd, op};
        legal = 1'b1;
      end
      3'd1: begin
        word  = {imm[11:0], rs1, f3, rd, op};
        legal = fits12;
      end
      3'd2: begin
        word  = {f7, imm[4:0], rs1, f3, rd, op};
        legal = imm[31:5] == '0;
      end
      3'd3: begin
        word  = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
        legal = fits12;
      end
      3'd4: begin
        word  = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
        legal = fits13 && !imm[0];
      end
      3'd5: begin
        word  = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
        legal = fits21 && !imm[0];
      end
      3'd6: begin
        word  = {imm[31:12], rd, op};
        legal = imm[11:0] == '0;
      end
      default: begin
        word  = '0;
        legal = 1'b0;
      end
    endcase
  end
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = accept ? ENCODE : IDLE;
      ENCODE:  state_n = legal ? WRITE : IDLE;
      WRITE:   state_n = !bus.mem_ack ? WRITE : count_n == depth_w ? STOP : IDLE;
      STOP:    state_n = bus.clear ? IDLE : STOP;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (accept) begin
      fmt <= bus.format;
      op  <= bus.opcode;
      f3  <= bus.funct3;
      f7  <= bus.funct7;
      rd  <= bus.rd;
      rs1 <= bus.rs1;
      rs2 <= bus.rs2;
      imm <= bus.imm;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      bus.in_ready  <= 1'b0;
      bus.mem_write <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.count     <= '0;
      bus.full      <= 1'b0;
      bus.error     <= 1'b0;
    end else begin
      state         <= state_n;
      bus.in_ready  <= state_n == IDLE;
      bus.mem_write <= state_n == WRITE;
      bus.full      <= state_n == STOP;
      if (state == ENCODE && legal) begin
        bus.mem_wdata <= word;
        bus.mem_addr  <= bus.count[ADDR_WIDTH-1:0];
      end
      if (state == WRITE && bus.mem_ack) bus.count <= count_n;
      if (state == ENCODE && !legal) bus.error <= 1'b1;
      if (idle_clear) begin
        bus.count <= '0;
        bus.error <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: randomized scoreboard bench for instr_encoder against a field-packing reference model.
module tb_instr_encoder;
  localparam int AW = 8, DEPTH = 4;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0, errors = 0, ack_mode = 0, model_count = 0;
  bit model_err = 1'b0;
  logic [48:0] exp_q[$];
  instr_encoder_if #(.ADDR_WIDTH(AW)) bus();
  instr_encoder #(.ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference packing built from shifted fields and signed range arithmetic.
  function automatic void model(input logic [31:0] f, op, f3, f7, rd, rs1, rs2, imm,
                                output bit ok, output logic [31:0] w);
    longint s;
    s  = longint'($signed(imm));
    ok = 1'b0;
    w  = '0;
    case (f)
      0: begin ok = 1'b1; w = (f7 << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op; end
      1: begin ok = s >= -2048 && s <= 2047; w = ((imm & 32'hFFF) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op; end
      2: begin ok = s >= 0 && s <= 31; w = (f7 << 25) | ((imm & 32'h1F) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op; end
      3: begin ok = s >= -2048 && s <= 2047;
         w = (((imm >> 5) & 32'h7F) << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | ((imm & 32'h1F) << 7) | op; end
      4: begin ok = s >= -4096 && s <= 4094 && (imm & 32'h1) == 0;
         w = (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3F) << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12)
           | (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 32'h1) << 7) | op; end
      5: begin ok = s >= -1048576 && s <= 1048574 && (imm & 32'h1) == 0;
         w = (((imm >> 20) & 32'h1) << 31) | (((imm >> 1) & 32'h3FF) << 21) | (((imm >> 11) & 32'h1) << 20)
           | (((imm >> 12) & 32'hFF) << 12) | (rd << 7) | op; end
      6: begin ok = (imm & 32'hFFF) == 0; w = (imm & 32'hFFFFF000) | (rd << 7) | op; end
      default: ok = 1'b0;
    endcase
  endfunction

  task automatic wait_ready();
    int n = 0;
    while (bus.in_ready !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
    if (bus.in_ready !== 1'b1) chk("ready_timeout", 32'(bus.in_ready), 1);
  endtask

  task automatic wait_full();
    int n = 0;
    while (bus.full !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
    chk("full_set", 32'(bus.full), 1);
    chk("stop_not_ready", 32'(bus.in_ready), 0);
  endtask

  task automatic send(input logic [31:0] f, op, f3, f7, rd, rs1, rs2, imm, output bit ok);
    logic [31:0] w;
    logic [8:0] c;
    wait_ready();
    bus.format = f[2:0]; bus.opcode = op[6:0]; bus.funct3 = f3[2:0]; bus.funct7 = f7[6:0];
    bus.rd = rd[4:0]; bus.rs1 = rs1[4:0]; bus.rs2 = rs2[4:0]; bus.imm = imm;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    model(f, op, f3, f7, rd, rs1, rs2, imm, ok, w);
    if (ok) begin
      c = 9'(model_count);
      model_count++;
      exp_q.push_back({c + 9'd1, c[7:0], w});
    end else model_err = 1'b1;
  endtask

  task automatic send_chk(input logic [31:0] f, op, f3, f7, rd, rs1, rs2, imm, exp_w, exp_a);
    bit ok;
    send(f, op, f3, f7, rd, rs1, rs2, imm, ok);
    @(negedge clk); chk("encode_no_write", 32'(bus.mem_write), 0);
    @(negedge clk); chk("write_strobe", 32'(bus.mem_write), 1);
    chk("write_addr", 32'(bus.mem_addr), exp_a);
    chk("write_data", bus.mem_wdata, exp_w);
    @(negedge clk); chk("after_write_ready", 32'(bus.in_ready), 1);
    chk("after_write_count", 32'(bus.count), 32'(model_count));
  endtask

  task automatic send_err(input logic [31:0] f, op, f3, f7, rd, rs1, rs2, imm);
    bit ok;
    send(f, op, f3, f7, rd, rs1, rs2, imm, ok);
    @(negedge clk); chk("err_no_write_c1", 32'(bus.mem_write), 0);
    @(negedge clk); chk("err_flag", 32'(bus.error), 1);
    chk("err_ready", 32'(bus.in_ready), 1);
    chk("err_no_write_c2", 32'(bus.mem_write), 0);
    chk("err_count", 32'(bus.count), 32'(model_count));
  endtask

  task automatic do_clear();
    int n = 0;
    while (!(bus.in_ready === 1'b1 || bus.full === 1'b1) && n < 100) begin @(posedge clk); #1; n++; end
    bus.clear = 1'b1; bus.in_valid = 1'b1; bus.format = 3'd1; bus.imm = 32'd7;
    @(posedge clk); #1;
    bus.clear = 1'b0; bus.in_valid = 1'b0;
    model_count = 0; model_err = 1'b0;
    @(negedge clk);
    chk("clear_count", 32'(bus.count), 0);
    chk("clear_full", 32'(bus.full), 0);
    chk("clear_error", 32'(bus.error), 0);
    chk("clear_ready", 32'(bus.in_ready), 1);
  endtask

  initial begin
    bus.mem_ack = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (ack_mode != 3) bus.mem_ack = ack_mode == 0 ? 1'b1 : ack_mode == 1 ? ($urandom_range(0, 2) != 0) : 1'b0;
    end
  end

  // Monitor: every acknowledged write pops the scoreboard; held writes must stay stable.
  initial begin
    logic prev_w;
    logic [31:0] prev_a, prev_d;
    logic [48:0] e;
    prev_w = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) prev_w = 1'b0;
      else if (bus.mem_write === 1'b1) begin
        if (prev_w) begin
          chk("addr_stable", 32'(bus.mem_addr), prev_a);
          chk("data_stable", bus.mem_wdata, prev_d);
        end
        prev_w = !bus.mem_ack;
        prev_a = 32'(bus.mem_addr);
        prev_d = bus.mem_wdata;
        if (bus.mem_ack) begin
          if (exp_q.size() == 0) chk("unexpected_write", 32'(bus.mem_write), 0);
          else begin
            e = exp_q.pop_front();
            chk("mem_addr", 32'(bus.mem_addr), 32'(e[39:32]));
            chk("mem_wdata", bus.mem_wdata, e[31:0]);
            @(negedge clk);
            chk("count", 32'(bus.count), 32'(e[48:40]));
          end
        end
      end else prev_w = 1'b0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    logic [31:0] f, imm;
    int n;
    bus.clear = 1'b0; bus.in_valid = 1'b0; bus.format = '0; bus.opcode = '0; bus.funct3 = '0;
    bus.funct7 = '0; bus.rd = '0; bus.rs1 = '0; bus.rs2 = '0; bus.imm = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(bus.in_ready), 0);
    chk("rst_write", 32'(bus.mem_write), 0);
    chk("rst_addr", 32'(bus.mem_addr), 0);
    chk("rst_wdata", bus.mem_wdata, 0);
    chk("rst_count", 32'(bus.count), 0);
    chk("rst_full", 32'(bus.full), 0);
    chk("rst_error", 32'(bus.error), 0);
    reset = 1'b0;
    ack_mode = 0;
    send_chk(1, 'h13, 0, 0, 1, 0, 0, 5, 32'h00500093, 0);
    do_clear();
    send_chk(0, 'h33, 0, 'h20, 3, 1, 2, 0, 32'h402081B3, 0);
    send_chk(4, 'h63, 0, 0, 0, 1, 2, 32'hFFFFFFF8, 32'hFE208CE3, 1);
    // jal with a stalled memory: write must hold for four cycles.
    ack_mode = 3; bus.mem_ack = 1'b0;
    send(5, 'h6F, 0, 0, 1, 0, 0, 2048, ok);
    @(negedge clk); chk("jal_encode", 32'(bus.mem_write), 0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      bus.mem_ack = i == 3;
      @(negedge clk);
      chk("jal_write", 32'(bus.mem_write), 1);
      chk("jal_ready", 32'(bus.in_ready), 0);
      chk("jal_data", bus.mem_wdata, 32'h001000EF);
      chk("jal_addr", 32'(bus.mem_addr), 2);
    end
    @(posedge clk); #1;
    bus.mem_ack = 1'b0; ack_mode = 0;
    @(negedge clk);
    chk("jal_done", 32'(bus.mem_write), 0);
    chk("jal_done_ready", 32'(bus.in_ready), 1);
    do_clear();
    send_err(1, 'h13, 0, 0, 1, 0, 0, 2048);
    send_err(4, 'h63, 0, 0, 0, 1, 2, 3);
    send_err(6, 'h37, 0, 0, 5, 0, 0, 32'h00001001);
    send_err(7, 'h13, 0, 0, 1, 0, 0, 0);
    send_chk(6, 'h37, 0, 0, 5, 0, 0, 32'h12345000, 32'h123452B7, 0);
    chk("error_sticky", 32'(bus.error), 1);
    do_clear();
    for (int k = 0; k < DEPTH; k++) send(1, 'h13, 0, 0, k + 1, 0, 0, k, ok);
    wait_full();
    bus.format = 3'd1; bus.imm = 32'd9; bus.in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("full_ignore_ready", 32'(bus.in_ready), 0);
      chk("full_ignore_write", 32'(bus.mem_write), 0);
      chk("full_ignore_count", 32'(bus.count), DEPTH);
    end
    do_clear();
    send_chk(1, 'h13, 0, 0, 1, 0, 0, 5, 32'h00500093, 0);
    // Reset during an unacknowledged write abandons it.
    ack_mode = 2;
    send(0, 'h33, 0, 0, 4, 5, 6, 0, ok);
    @(negedge clk);
    @(negedge clk); chk("rw_write_before", 32'(bus.mem_write), 1);
    reset = 1'b1;
    @(negedge clk);
    chk("rw_write", 32'(bus.mem_write), 0);
    chk("rw_ready", 32'(bus.in_ready), 0);
    chk("rw_count", 32'(bus.count), 0);
    chk("rw_addr", 32'(bus.mem_addr), 0);
    chk("rw_wdata", bus.mem_wdata, 0);
    chk("rw_full", 32'(bus.full), 0);
    chk("rw_error", 32'(bus.error), 0);
    reset = 1'b0;
    exp_q.delete();
    model_count = 0; model_err = 1'b0;
    ack_mode = 1;
    for (int i = 0; i < 300; i++) begin
      if (model_count == DEPTH) begin wait_full(); do_clear(); end
      else if ($urandom_range(0, 15) == 0) do_clear();
      wait_ready();
      chk("rand_error", 32'(bus.error), 32'(model_err));
      f = $urandom_range(0, 7);
      case ($urandom_range(0, 4))
        0: imm = $urandom;
        1: imm = $urandom_range(0, 8191) - 4096;
        2: imm = $urandom & 32'hFFFFF000;
        3: imm = $urandom_range(0, 2097151) - 1048576;
        default: imm = $urandom_range(0, 40);
      endcase
      send(f, $urandom_range(0, 127), $urandom_range(0, 7), $urandom_range(0, 127),
           $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31), imm, ok);
    end
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin @(posedge clk); n++; end
    chk("drain", 32'(exp_q.size()), 0);
    repeat (2) @(negedge clk);
    chk("final_count", 32'(bus.count), 32'(model_count));
    chk("final_error", 32'(bus.error), 32'(model_err));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
